// File: rtl/if_id_queue_pkg.sv
// Shared constants for the IF/ID instruction queue: NOP encoding, reset PC
// and the packed entry width {pc, inst, npc, pred_taken}.
package if_id_queue_pkg;

    localparam logic [31:0] INST_NOP    = 32'h0340_0000;
    localparam logic [31:0] INIT_ADDR   = 32'h1c00_0000;
    localparam int          XLEN_DEF    = 32;
    localparam int          IFQ_ENTRY_W = 3 * XLEN_DEF + 1;

    function automatic int ifq_entry_w(input int xlen);
        return 3 * xlen + 1;
    endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch/decode side bundle of the IF/ID queue. The master drives pushes,
// accepts and flush; the slave (the queue) drives ready, head entries and count.
interface if_id_queue_if #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
);
    logic                    flush;
    logic [1:0]              in_valid;
    logic [2*XLEN-1:0]       in_pc;
    logic [2*XLEN-1:0]       in_inst;
    logic [2*XLEN-1:0]       in_npc;
    logic [1:0]              in_pred_taken;
    logic                    in_ready;
    logic [1:0]              out_valid;
    logic [2*XLEN-1:0]       out_pc;
    logic [2*XLEN-1:0]       out_inst;
    logic [2*XLEN-1:0]       out_npc;
    logic [1:0]              out_pred_taken;
    logic [1:0]              out_accept;
    logic [$clog2(DEPTH):0]  count;

    modport master (
        output flush, in_valid, in_pc, in_inst, in_npc, in_pred_taken, out_accept,
        input  in_ready, out_valid, out_pc, out_inst, out_npc, out_pred_taken, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_inst, in_npc, in_pred_taken, out_accept,
        output in_ready, out_valid, out_pc, out_inst, out_npc, out_pred_taken, count
    );

endinterface

// File: rtl/if_id_queue_mem.sv
// Entry storage: two write ports with enables, two asynchronous read ports.
// The array is never reset; invalid slots are masked by the queue control.
module if_id_queue_mem #(
    parameter  int DEPTH = 8,
    parameter  int W     = 97,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          aclk,
    input  logic          we0_i,
    input  logic          we1_i,
    input  logic [AW-1:0] waddr0_i,
    input  logic [AW-1:0] waddr1_i,
    input  logic [W-1:0]  wdata0_i,
    input  logic [W-1:0]  wdata1_i,
    input  logic [AW-1:0] raddr0_i,
    input  logic [AW-1:0] raddr1_i,
    output logic [W-1:0]  rdata0_o,
    output logic [W-1:0]  rdata1_o
);

    logic [W-1:0] mem_q [DEPTH];

    // Write both push slots; the two addresses always differ when both enabled.
    always_ff @(posedge aclk) begin
        if (we0_i) mem_q[waddr0_i] <= wdata0_i;
        if (we1_i) mem_q[waddr1_i] <= wdata1_i;
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/if_id_queue.sv
// Dual-issue IF/ID instruction queue: circular buffer control, push/pop
// handshake and NOP masking of the two head slots.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic          aclk,
    input  logic          aresetn,
    if_id_queue_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = ifq_entry_w(XLEN);

    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    push_n, pop_n, acc, valid;
    logic          ready;
    logic [EW-1:0] wdata0, wdata1, rdata0, rdata1;

    // Ready only depends on registered occupancy, never on a same-cycle pop.
    assign ready = (count_q <= CW'(DEPTH - 2));

    // Head availability from occupancy: 00, 01 or 11 only.
    always_comb begin
        valid = 2'b00;
        if (count_q >= CW'(2))      valid = 2'b11;
        else if (count_q == CW'(1)) valid = 2'b01;
    end

    assign acc = bus.out_accept & valid;

    // Push/pop amounts are prefix lengths; 10 patterns collapse to zero.
    always_comb begin
        push_n = 2'd0;
        pop_n  = 2'd0;
        if (ready && bus.in_valid[0]) push_n = bus.in_valid[1] ? 2'd2 : 2'd1;
        if (acc[0])                   pop_n  = acc[1] ? 2'd2 : 2'd1;
    end

    // Next pointer/occupancy values for a normal (non-flush) cycle.
    always_comb begin
        wptr_d  = wptr_q + AW'(push_n);
        rptr_d  = rptr_q + AW'(pop_n);
        count_d = count_q + CW'(push_n) - CW'(pop_n);
    end

    // Reset and flush both drop every entry at the next edge.
    always_ff @(posedge aclk) begin
        if (!aresetn || bus.flush) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    assign wdata0 = {bus.in_pc[0 +: XLEN], bus.in_inst[0 +: XLEN],
                     bus.in_npc[0 +: XLEN], bus.in_pred_taken[0]};
    assign wdata1 = {bus.in_pc[XLEN +: XLEN], bus.in_inst[XLEN +: XLEN],
                     bus.in_npc[XLEN +: XLEN], bus.in_pred_taken[1]};

    if_id_queue_mem #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_mem (
        .aclk     (aclk),
        .we0_i    (push_n != 2'd0),
        .we1_i    (push_n == 2'd2),
        .waddr0_i (wptr_q),
        .waddr1_i (wptr_q + AW'(1)),
        .wdata0_i (wdata0),
        .wdata1_i (wdata1),
        .raddr0_i (rptr_q),
        .raddr1_i (rptr_q + AW'(1)),
        .rdata0_o (rdata0),
        .rdata1_o (rdata1)
    );

    // Unpack head entries and replace invalid slots with NOP / reset PC.
    always_comb begin
        bus.out_pc         = {XLEN'(INIT_ADDR), XLEN'(INIT_ADDR)};
        bus.out_npc        = {XLEN'(INIT_ADDR), XLEN'(INIT_ADDR)};
        bus.out_inst       = {XLEN'(INST_NOP), XLEN'(INST_NOP)};
        bus.out_pred_taken = 2'b00;
        if (valid[0]) begin
            bus.out_pc[0 +: XLEN]   = rdata0[EW-1 -: XLEN];
            bus.out_inst[0 +: XLEN] = rdata0[EW-1-XLEN -: XLEN];
            bus.out_npc[0 +: XLEN]  = rdata0[XLEN:1];
            bus.out_pred_taken[0]   = rdata0[0];
        end
        if (valid[1]) begin
            bus.out_pc[XLEN +: XLEN]   = rdata1[EW-1 -: XLEN];
            bus.out_inst[XLEN +: XLEN] = rdata1[EW-1-XLEN -: XLEN];
            bus.out_npc[XLEN +: XLEN]  = rdata1[XLEN:1];
            bus.out_pred_taken[1]      = rdata1[0];
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid;
    assign bus.count     = count_q;

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised dual-issue instruction queue between fetch (IF) and decode (ID); replaces the single-entry IF/ID pipeline register. Fetch pushes 0–2 instruction bundles per cycle, each with PC, predicted next PC and predicted-taken flag; decode pops 0–2 per cycle in program order. Flush empties the queue in one cycle. Back-pressure is expressed through `in_ready` and decode accept, not through stall vectors.

## Interface
- `DEPTH`, default 8: number of entries; power of two, at least 4.
- `XLEN`, default 32: PC and instruction width.
- `aclk`  in  1: clock.
- `aresetn`  in  1: synchronous, active-low reset.
- `flush`  in  1: discard all entries. Overrides push and pop in the same cycle.
- `in_valid`  in  2: push slot valid. Slot 1 counts only when slot 0 is valid (`10` is treated as `00`).
- `in_pc`  in  2*XLEN: slot *i* at bits [i*XLEN +: XLEN].
- `in_inst`  in  2*XLEN: instruction word per slot.
- `in_npc`  in  2*XLEN: predicted next PC per slot.
- `in_pred_taken`  in  2: branch-predicted-taken flag per slot.
- `in_ready`  out  1: queue can accept a full 2-wide push this cycle.
- `out_valid`  out  2: head entries available. Always `00`, `01` or `11`.
- `out_pc`, `out_inst`, `out_npc`  out  2*XLEN: head entry (slot 0) and head+1 (slot 1).
- `out_pred_taken`  out  2: predicted-taken flag for each output slot.
- `out_accept`  in  2: decode consumes slots. Must be a prefix (`00`, `01`, `11`). The block masks it with `out_valid`, and a non-prefix value is treated as the slot-0 bit only.
- `count`  out  clog2(DEPTH)+1: current occupancy.

## Operation
- **Storage.** Circular buffer with read pointer `rptr` and write pointer `wptr`, each clog2(DEPTH) bits and wrapping modulo DEPTH, plus the `count` register.
- **Push count.** `push_n` is 0, 1 or 2 and equals the number of leading valid `in_valid` bits, gated by `in_ready`. When `in_ready` is 0 the whole push is dropped; fetch must hold its bundle.
- **Pop count.** `pop_n` is 0, 1 or 2 and equals the prefix length of `out_accept & out_valid`.
- **Normal update:**
  - Slot *i* is written at `(wptr+i) mod DEPTH`.
  - `wptr += push_n`, `rptr += pop_n`.
  - `count += push_n - pop_n`.
- **Simultaneous push and pop** are legal at any occupancy. Pop reads the pre-cycle contents, so there is no same-cycle bypass.
- **`in_ready`** is `(DEPTH - count) >= 2`, combinational from the registered `count` only. It does not depend on the same-cycle pop.
- **`out_valid`:**
  - `count == 0` gives `00`.
  - `count == 1` gives `01`.
  - `count >= 2` gives `11`.
- **Invalid output slots** drive `out_inst = INST_NOP`, `out_pc = out_npc = INIT_ADDR` and `out_pred_taken = 0`.
- **Flush:** `rptr`, `wptr` and `count` are cleared to 0 on the next edge. Pushes and pops in the flush cycle have no effect.
- **Reset** (`aresetn` low at an edge) behaves the same as flush. Storage contents are not cleared; they are don't-care behind the NOP masking.

## Timing
- **Latency.** An entry pushed at edge N is visible on `out_*` after edge N, i.e. in cycle N+1, if it is at the head.
- **Throughput.** Sustained 2 pushes and 2 pops per cycle.
- **Outputs after reset or flush:**
  - `count = 0`, `out_valid = 00`, `in_ready = 1`.
  - `out_inst` = NOP on both slots.
  - `out_pc` = `out_npc` = INIT_ADDR.
- **Full boundary.** With `count = DEPTH-1`, `in_ready = 0` even if decode pops 2 that cycle; the queue therefore never exceeds DEPTH.
- **Empty boundary.** `out_accept` with `out_valid = 00` has no effect, and `count` never underflows.
- **Wrap.** A 2-wide push at `wptr = DEPTH-1` writes entries DEPTH-1 and 0. The output slot-1 read wraps the same way.
- **Reset mid-operation.** Same as flush; nothing partial survives.

## Structure
- `INST_NOP` and `INIT_ADDR` come from `define.vh`.
- Add `IFQ_ENTRY_W` (= 3*XLEN+1) to the same header.
- Sub-module `if_id_queue_mem`: DEPTH×IFQ_ENTRY_W register array with 2 write ports (with enables) and 2 asynchronous read ports. No reset on the array.
- `if_id_queue` holds the pointers, `count`, handshake logic and NOP masking. It packs each entry as {pc, inst, npc, pred_taken}.

## Test plan
- **Reset.** Pulse `aresetn` low for 2 cycles -> `count = 0`, `out_valid = 00`, `in_ready = 1`, `out_inst` = NOP on both slots.
- **Single push.** Push `in_valid = 11` with pc 0x1c000000/0x1c000004 and no accept -> next cycle `out_valid = 11`, `out_pc` matches, `count = 2`. Then accept `01` -> `out_pc` slot 0 = 0x1c000004, `out_valid = 01`.
- **Fill to full.** Push 2 per cycle with DEPTH=8 and no pops -> `in_ready` falls when `count = 7` or `8`. A push attempted while `in_ready = 0` is dropped and `count` is unchanged.
- **Wrap-around.** Run 20 cycles of 2-in/2-out with pc incrementing by 4 -> output pc sequence is contiguous with no gaps, `count` steady, pointers wrap correctly.
- **Flush with concurrent traffic.** Assert `flush` with `count = 5` while pushing `11` and accepting `11` -> next cycle `count = 0`, `out_valid = 00`. The flushed entries never appear.
- **Illegal inputs.** Drive `in_valid = 10` -> no push. Drive `out_accept = 10` with `out_valid = 11` -> no pop.
